// File: rtl/cdc_clear_initiator.sv
// Source-domain initiator of the CDC FIFO clear handshake: sequences local isolate/clear
// and drives a two-phase req/phase channel to the peer-domain responder.
module cdc_clear_initiator #(
   parameter int unsigned SYNC_STAGES          = 2,
   parameter bit          CLEAR_ON_ASYNC_RESET = 1'b1
) (
   input  logic       src_clk_i,
   input  logic       src_rst_ni,
   input  logic       src_clear_i,
   output logic       src_isolate_o,
   input  logic       src_isolate_ack_i,
   output logic       src_clear_o,
   output logic       src_clear_pending_o,
   output logic       async_req_o,
   output logic [1:0] async_phase_o,
   input  logic       async_ack_i
);

   typedef enum logic [2:0] {
      RESYNC  = 3'd0,
      IDLE    = 3'd1,
      ISOLATE = 3'd2,
      CLEAR   = 3'd3,
      POST    = 3'd4
   } state_e;

   localparam logic [1:0] PH_ISOLATE = 2'd1;
   localparam logic [1:0] PH_CLEAR   = 2'd2;
   localparam logic [1:0] PH_POST    = 2'd3;

   localparam int unsigned   CNT_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYNC_STAGES);

   if (SYNC_STAGES < 2) begin : gen_bad_sync_stages
      $fatal(1, "cdc_clear_initiator: SYNC_STAGES must be at least 2");
   end

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   req_q, req_d;
   logic [1:0]             phase_q, phase_d;
   logic                   isolate_q, isolate_d;
   logic                   clear_q, clear_d;
   logic                   loc_done_q, loc_done_d;
   logic                   rem_done_q, rem_done_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
   logic                   hs_done;
   logic                   loc_ok;
   logic                   rem_ok;

   // Acknowledge toggle arrives from the peer clock domain and must be synchronized first.
   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_ack_i};
      end
   end

   assign ack_s   = sync_q[SYNC_STAGES-1];
   assign hs_done = (ack_s == req_q);
   assign loc_ok  = loc_done_q | src_isolate_ack_i;
   assign rem_ok  = rem_done_q | hs_done;

   // State register plus all registered outputs and sticky flags.
   always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
      if (!src_rst_ni) begin
         state_q    <= RESYNC;
         cnt_q      <= '0;
         req_q      <= 1'b0;
         phase_q    <= 2'd0;
         isolate_q  <= CLEAR_ON_ASYNC_RESET;
         clear_q    <= 1'b0;
         loc_done_q <= 1'b0;
         rem_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_q      <= req_d;
         phase_q    <= phase_d;
         isolate_q  <= isolate_d;
         clear_q    <= clear_d;
         loc_done_q <= loc_done_d;
         rem_done_q <= rem_done_d;
      end
   end

   // Next-state logic; the ISOLATE exit also accepts flags that become true this cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RESYNC: begin
            if (cnt_q == CNT_LAST) begin
               state_d = CLEAR_ON_ASYNC_RESET ? ISOLATE : IDLE;
            end
         end
         IDLE: begin
            if (src_clear_i) begin
               state_d = ISOLATE;
            end
         end
         ISOLATE: begin
            if (loc_ok && rem_ok) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            if (hs_done) begin
               state_d = POST;
            end
         end
         POST: begin
            if (hs_done) begin
               state_d = IDLE;
            end
         end
         default: state_d = RESYNC;
      endcase
   end

   // Output logic: RESYNC realigns req to the peer's ack level, each state entry sends a phase.
   always_comb begin
      cnt_d      = '0;
      req_d      = req_q;
      phase_d    = phase_q;
      isolate_d  = isolate_q;
      clear_d    = 1'b0;
      loc_done_d = 1'b0;
      rem_done_d = 1'b0;

      unique case (state_q)
         RESYNC: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               req_d = ack_s;
            end
         end
         ISOLATE: begin
            loc_done_d = loc_ok && (state_d == ISOLATE);
            rem_done_d = rem_ok && (state_d == ISOLATE);
         end
         POST: begin
            if (state_d == IDLE) begin
               isolate_d = 1'b0;
            end
         end
         default: ;
      endcase

      if (state_d != state_q) begin
         unique case (state_d)
            ISOLATE: begin
               isolate_d = 1'b1;
               req_d     = ~req_d;
               phase_d   = PH_ISOLATE;
            end
            CLEAR: begin
               clear_d = 1'b1;
               req_d   = ~req_q;
               phase_d = PH_CLEAR;
            end
            POST: begin
               req_d   = ~req_q;
               phase_d = PH_POST;
            end
            default: ;
         endcase
      end
   end

   assign src_isolate_o       = isolate_q;
   assign src_clear_o         = clear_q;
   assign async_req_o         = req_q;
   assign async_phase_o       = phase_q;
   assign src_clear_pending_o = (state_q != IDLE);

   a_clear_only_in_idle : assert property (
      @(posedge src_clk_i) disable iff (!src_rst_ni)
      src_clear_i |-> (state_q == IDLE)
   ) else $warning("cdc_clear_initiator: src_clear_i outside IDLE is ignored");

   a_isolated_during_clear : assert property (
      @(posedge src_clk_i) disable iff (!src_rst_ni)
      src_clear_o |-> src_isolate_o
   ) else $error("cdc_clear_initiator: src_clear_o raised without isolation");

endmodule

// File: tb/tb_cdc_clear_initiator.sv
// Self-checking bench for cdc_clear_initiator: event-time model of the clear sequence,
// checked against a loopback responder with a configurable ack delay.
module tb_cdc_clear_initiator;

   localparam int S = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0_n = 1'b1;
   logic       clr0 = 1'b0;
   logic       iso_ack0 = 1'b0;
   logic       iso0, clro0, pend0, req0, ack0;
   logic [1:0] ph0;

   logic       rst1_n = 1'b1;
   logic       clr1 = 1'b0;
   logic       iso1_d = 1'b0;
   logic       iso1, clro1, pend1, req1;
   logic [1:0] ph1;

   logic [7:0] req_hist = 8'h00;
   logic [2:0] dly = 3'd0;
   logic       force_en = 1'b0;
   logic       force_val = 1'b0;
   logic       sel1 = 1'b0;

   logic       o_iso, o_clr, o_pend, o_req;
   logic [1:0] o_ph;

   int         vectors = 0;
   int         miscompares = 0;

   logic       m_req = 1'b0;
   logic [1:0] m_ph = 2'd0;

   // Responder stand-in: echoes req after dly cycles, or holds a forced level.
   always @(posedge clk) req_hist <= {req_hist[6:0], req0};
   always @(posedge clk) iso1_d <= iso1;

   always_comb begin
      if (force_en)         ack0 = force_val;
      else if (dly == 3'd0) ack0 = req0;
      else                  ack0 = req_hist[dly - 3'd1];
   end

   always_comb begin
      o_iso  = sel1 ? iso1  : iso0;
      o_clr  = sel1 ? clro1 : clro0;
      o_pend = sel1 ? pend1 : pend0;
      o_req  = sel1 ? req1  : req0;
      o_ph   = sel1 ? ph1   : ph0;
   end

   cdc_clear_initiator #(.SYNC_STAGES(S), .CLEAR_ON_ASYNC_RESET(1'b0)) u_dut0 (
      .src_clk_i           (clk),
      .src_rst_ni          (rst0_n),
      .src_clear_i         (clr0),
      .src_isolate_o       (iso0),
      .src_isolate_ack_i   (iso_ack0),
      .src_clear_o         (clro0),
      .src_clear_pending_o (pend0),
      .async_req_o         (req0),
      .async_phase_o       (ph0),
      .async_ack_i         (ack0)
   );

   cdc_clear_initiator #(.SYNC_STAGES(S), .CLEAR_ON_ASYNC_RESET(1'b1)) u_dut1 (
      .src_clk_i           (clk),
      .src_rst_ni          (rst1_n),
      .src_clear_i         (clr1),
      .src_isolate_o       (iso1),
      .src_isolate_ack_i   (iso1_d),
      .src_clear_o         (clro1),
      .src_clear_pending_o (pend1),
      .async_req_o         (req1),
      .async_phase_o       (ph1),
      .async_ack_i         (req1)
   );

   task automatic checkOutput(input string tag, input int t, input logic [1:0] obs, input logic [1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
      end
   endtask

   task automatic checkAll(input int t, input logic e_iso, input logic e_clr, input logic e_pend,
                           input logic e_req, input logic [1:0] e_ph);
      checkOutput("isolate", t, {1'b0, o_iso}, {1'b0, e_iso});
      checkOutput("clear", t, {1'b0, o_clr}, {1'b0, e_clr});
      checkOutput("pending", t, {1'b0, o_pend}, {1'b0, e_pend});
      checkOutput("req", t, {1'b0, o_req}, {1'b0, e_req});
      checkOutput("phase", t, o_ph, e_ph);
   endtask

   // Entered at a negedge in cycle t=0 (the trigger cycle). Each phase completes
   // dr+S cycles after its toggle, and the next state shows one cycle later.
   task automatic applyStimulus(input int dr, input int la, input bit hold_ack, input bit pulse,
                                input bit abuse, input bit abort, input logic iso_before,
                                input logic pend_before);
      int c_ev, p_ev, i_ev, last;
      logic e_iso, e_pend, e_req;
      logic [1:0] e_ph;
      c_ev = (((1 + dr + S) > la) ? (1 + dr + S) : la) + 1;
      p_ev = c_ev + dr + S + 1;
      i_ev = p_ev + dr + S + 1;
      last = abort ? p_ev : i_ev + 2;
      if (!sel1) dly = 3'(dr);
      for (int t = 0; t <= last; t++) begin
         if (t > 0) @(negedge clk);
         if (!sel1) begin
            clr0     = (pulse && t == 0) || (abuse && t == c_ev);
            iso_ack0 = hold_ack ? (t >= la && t < i_ev) : (t == la);
         end
         e_iso  = (t < 1) ? iso_before  : (t < i_ev);
         e_pend = (t < 1) ? pend_before : (t < i_ev);
         e_req  = m_req ^ (t >= 1) ^ (t >= c_ev) ^ (t >= p_ev);
         if (t < 1)         e_ph = m_ph;
         else if (t < c_ev) e_ph = 2'd1;
         else if (t < p_ev) e_ph = 2'd2;
         else               e_ph = 2'd3;
         checkAll(t, e_iso, (t == c_ev), e_pend, e_req, e_ph);
      end
      clr0     = 1'b0;
      iso_ack0 = 1'b0;
      if (!abort) begin
         m_req = ~m_req;
         m_ph  = 2'd3;
      end
   endtask

   // Asserts reset now, checks reset values at once, releases at a negedge and follows RESYNC.
   task automatic resetDut0();
      rst0_n = 1'b0;
      #1;
      checkAll(-1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      @(negedge clk);
      checkAll(-1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
      rst0_n = 1'b1;
      m_req  = force_en ? force_val : 1'b0;
      m_ph   = 2'd0;
      for (int t = 0; t <= 8; t++) begin
         if (t > 0) @(negedge clk);
         if (t < S + 1) checkAll(t, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
         else           checkAll(t, 1'b0, 1'b0, 1'b0, m_req, 2'd0);
      end
   endtask

   initial begin
      #1 rst1_n = 1'b0;
      $display("[TB] start");

      @(negedge clk);
      resetDut0();

      @(negedge clk);
      $display("[TB] loopback sequence");
      applyStimulus(0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      $display("[TB] late local ack");
      applyStimulus(0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      $display("[TB] clear pulse during CLEAR");
      applyStimulus(1, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      $display("[TB] single-cycle local ack");
      applyStimulus(2, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] randomized sequences");
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(1, 4)) @(negedge clk);
         applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(1, 12)),
                       1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                       1'b0, 1'b0, 1'b0);
      end

      @(negedge clk);
      $display("[TB] reset in POST");
      applyStimulus(1, 2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #2;
      resetDut0();

      @(negedge clk);
      $display("[TB] one-sided reset, peer ack high");
      force_en  = 1'b1;
      force_val = 1'b1;
      resetDut0();
      force_en = 1'b0;
      repeat (5) @(negedge clk);
      applyStimulus(int'($urandom_range(0, 3)), 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      $display("[TB] clear on async reset");
      sel1  = 1'b1;
      m_req = 1'b0;
      m_ph  = 2'd0;
      #1;
      checkAll(-1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      @(negedge clk);
      rst1_n = 1'b1;
      for (int t = 0; t < S; t++) begin
         if (t > 0) @(negedge clk);
         checkAll(t, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
      end
      @(negedge clk);
      applyStimulus(0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cdc_clear_initiator.md
# cdc_clear_initiator

Source-domain initiator of the clear handshake used by the clearable CDC FIFOs: it drives the local isolate and clear sequence and the matching two-phase request channel to a responder in the peer clock domain. Triggers are a functional clear pulse or, optionally, release of the local asynchronous reset. It realigns the two-phase channel after a one-sided reset, so the initiator can be reset on its own. It sits in the source domain next to the FIFO source half; the responder is a separate block.

## Interface
- SYNC_STAGES, 2: synchronizer depth on async_ack_i; must be >= 2.
- CLEAR_ON_ASYNC_RESET, 1: 1 = a full clear sequence runs automatically after reset release; 0 = only src_clear_i starts one.
- src_clk_i  in  1  source clock.
- src_rst_ni  in  1  reset src_rst_ni, asynchronous, active-low; clock src_clk_i.
- src_clear_i  in  1  functional clear request; single-cycle pulse; accepted only in IDLE.
- src_isolate_o  out  1  registered; asks the local logic to stop valid/ready traffic.
- src_isolate_ack_i  in  1  local logic confirms isolation.
- src_clear_o  out  1  registered; single-cycle synchronous clear to the local logic.
- src_clear_pending_o  out  1  high whenever the state is not IDLE.
- async_req_o  out  1  registered two-phase request toggle to the responder.
- async_phase_o  out  2  registered phase code; 1 = ISOLATE, 2 = CLEAR, 3 = POST_CLEAR, 0 = none.
- async_ack_i  in  1  two-phase acknowledge toggle from the responder; asynchronous input.

## Operation
- async_ack_i passes through a SYNC_STAGES-deep sync to give ack_s.
- A handshake is complete when ack_s == req_q.
- Sending a phase: req_q and phase_q are updated on the same edge (req_q toggles, phase_q takes the new code). phase_q then holds until the next send. A new send only happens after the previous handshake is complete.
- States: RESYNC, IDLE, ISOLATE, CLEAR, POST.
- RESYNC (entered at reset):
  - A counter runs for SYNC_STAGES+1 cycles; src_clear_i is ignored.
  - On the last cycle req_q <= ack_s, with no toggle and phase_q unchanged.
  - Next state is ISOLATE if CLEAR_ON_ASYNC_RESET, else IDLE.
- IDLE: on src_clear_i, go to ISOLATE.
- ISOLATE:
  - On entry: src_isolate_o <= 1 and send phase ISOLATE.
  - Two sticky flags: loc_done sets on src_isolate_ack_i; rem_done sets on handshake complete.
  - When both are set (in either order or the same cycle), go to CLEAR.
- CLEAR:
  - On entry: src_clear_o is high for exactly the entry cycle, and phase CLEAR is sent.
  - On handshake complete, go to POST.
- POST:
  - On entry: send phase POST_CLEAR.
  - On handshake complete, go to IDLE and set src_isolate_o <= 0.
- src_isolate_o stays high from ISOLATE entry until IDLE entry. It is never low while src_clear_o is high.
- src_clear_i outside IDLE is a protocol violation: ignored, with a simulation assertion.
- Dropping src_isolate_ack_i after it was seen has no effect, because loc_done is sticky.
- Reset mid-sequence: all state returns to reset values asynchronously. The sequence restarts from RESYNC; no partial state is kept.

## Timing
- Reset values:
  - src_isolate_o = CLEAR_ON_ASYNC_RESET.
  - src_clear_o = 0, async_req_o = 0, async_phase_o = 0.
  - src_clear_pending_o = 1.
  - sync stages = 0, loc_done = rem_done = 0.
- All outputs are registered except src_clear_pending_o, which is decoded from the state register.
- Cycle n is the cycle in which src_clear_i is high in IDLE.
  - Cycle n+1: ISOLATE entry; req toggles.
  - Handshake is seen at the earliest SYNC_STAGES cycles after the toggle.
  - The state change is visible one cycle after detection.
- Minimum sequence length, with the responder acking instantly: 3*(SYNC_STAGES+1)+1 cycles from src_clear_i to pending low.
- Phase code is stable for a whole handshake, so the responder samples it after synchronizing req, with no extra sync.

## Test plan
- Loopback, part 1 (SYNC_STAGES=2, CLEAR_ON_ASYNC_RESET=0):
  - Setup: async_ack_i = async_req_o; src_isolate_ack_i = src_isolate_o delayed 1 cycle.
  - Idle check after RESYNC: pending=0.
  - Stimulus: src_clear_i pulse at cycle 0.
  - Cycle 1: isolate=1, req=1, phase=1.
  - Cycle 4: clear_o=1 for one cycle, req=0, phase=2.
  - Cycle 7: req=1, phase=3.
- Loopback, part 2: cycle 10 gives isolate=0, pending=0.
- Local ack late: src_isolate_ack_i is held 0 until cycle 8 -> CLEAR entry at cycle 9, not 4; the remote ack arriving first is remembered.
- CLEAR_ON_ASYNC_RESET=1, loopback:
  - During reset: isolate=1, pending=1.
  - Reset release: RESYNC lasts 3 cycles, then ISOLATE entry with req toggling 0->1.
  - A full sequence completes without src_clear_i.
- One-sided reset with peer ack at 1:
  - Stimulus: force async_ack_i=1 and no loopback, then release reset.
  - After RESYNC: req_q=1, no false handshake, no phase sent (CLEAR_ON_ASYNC_RESET=0) -> IDLE.
- Abuse cases:
  - src_clear_i pulsed in CLEAR -> ignored (assertion), sequence unchanged.
  - Reset asserted while in POST -> all outputs return to reset values immediately, then RESYNC.
